// File: rtl/conv_pkg.sv
// Shared constants and operand types for the 3x3 convolution engine.
// Accumulator width covers nine 16-bit products plus an 8-bit bias.
package conv_pkg;

  localparam int DATA_W = 8;
  localparam int OUT_W  = 10;
  localparam int K      = 3;
  localparam int NTAPS  = K * K;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 21;

  localparam logic [OUT_W-1:0] OUT_MAX = {OUT_W{1'b1}};

  typedef logic [DATA_W-1:0]      pixel_t;
  typedef pixel_t [K-1:0][K-1:0]  patch_t;
  typedef logic [ACC_W-1:0]       acc_t;

endpackage

// File: rtl/conv_mac9.sv
// Combinational 9-tap multiply plus bias, reduced through a balanced 5/3/2/1 adder tree.
// Zero latency; no flow control, result follows the operands.
module conv_mac9
  import conv_pkg::*;
(
  input  patch_t patch,
  input  patch_t kernel,
  input  pixel_t bias,
  output acc_t   acc
);

  logic [PROD_W-1:0] prod [NTAPS];
  logic [PROD_W:0]   s1   [5];
  logic [PROD_W+1:0] s2   [3];
  logic [PROD_W+2:0] s3   [2];
  logic [PROD_W+3:0] s4;

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        prod[r*K+c] = PROD_W'(patch[r][c]) * PROD_W'(kernel[r][c]);
      end
    end
  end

  // Bias rides in the first stage as the tenth term so the tree stays balanced.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s1[i] = {1'b0, prod[2*i]} + {1'b0, prod[2*i+1]};
    end
    s1[4] = {1'b0, prod[8]} + (PROD_W+1)'(bias);
  end

  always_comb begin
    s2[0] = {1'b0, s1[0]} + {1'b0, s1[1]};
    s2[1] = {1'b0, s1[2]} + {1'b0, s1[3]};
    s2[2] = {1'b0, s1[4]};
  end

  always_comb begin
    s3[0] = {1'b0, s2[0]} + {1'b0, s2[1]};
    s3[1] = {1'b0, s2[2]};
  end

  assign s4  = {1'b0, s3[0]} + {1'b0, s3[1]};
  assign acc = ACC_W'(s4);

endmodule

// File: rtl/convolution_3x3.sv
// 3x3 convolution: patch . kernel + bias, saturated to OUT_W bits and registered.
// Latency 1 cycle, one result per clock, no handshake.
module convolution_3x3
  import conv_pkg::*;
#(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int OUT_W  = conv_pkg::OUT_W,
  parameter int K      = conv_pkg::K
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [K-1:0][K-1:0][DATA_W-1:0]    input_patch,
  input  logic [K-1:0][K-1:0][DATA_W-1:0]    kernel,
  input  logic [DATA_W-1:0]                  bias,
  output logic [OUT_W-1:0]                   output_pixel
);

  localparam acc_t SAT_LIMIT = acc_t'((ACC_W'(1) << OUT_W) - 1);

  acc_t             acc;
  logic [OUT_W-1:0] pixel_next;

  conv_mac9 u_mac9 (
    .patch  (input_patch),
    .kernel (kernel),
    .bias   (bias),
    .acc    (acc)
  );

  always_comb begin
    pixel_next = acc[OUT_W-1:0];
    if (acc > SAT_LIMIT) begin
      pixel_next = {OUT_W{1'b1}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_pixel <= '0;
    end else begin
      output_pixel <= pixel_next;
    end
  end

endmodule

// File: tb/tb_convolution_3x3.sv
module tb_convolution_3x3;

  logic                   clk;
  logic                   rst;
  logic [2:0][2:0][7:0]   input_patch;
  logic [2:0][2:0][7:0]   kernel;
  logic [7:0]             bias;
  logic [9:0]             output_pixel;

  int checks;
  int errors;

  convolution_3x3 dut (
    .clk          (clk),
    .rst          (rst),
    .input_patch  (input_patch),
    .kernel       (kernel),
    .bias         (bias),
    .output_pixel (output_pixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0][2:0][7:0] mk(
    input logic [7:0] a00, input logic [7:0] a01, input logic [7:0] a02,
    input logic [7:0] a10, input logic [7:0] a11, input logic [7:0] a12,
    input logic [7:0] a20, input logic [7:0] a21, input logic [7:0] a22);
    logic [2:0][2:0][7:0] p;
    p[0][0] = a00; p[0][1] = a01; p[0][2] = a02;
    p[1][0] = a10; p[1][1] = a11; p[1][2] = a12;
    p[2][0] = a20; p[2][1] = a21; p[2][2] = a22;
    return p;
  endfunction

  function automatic logic [2:0][2:0][7:0] uni(input logic [7:0] v);
    return mk(v, v, v, v, v, v, v, v, v);
  endfunction

  task automatic apply(input logic [2:0][2:0][7:0] p, input logic [2:0][2:0][7:0] k,
                       input logic [7:0] b);
    @(negedge clk);
    input_patch = p;
    kernel      = k;
    bias        = b;
  endtask

  task automatic test_reset;
    rst         = 1'b1;
    input_patch = uni(8'd99);
    kernel      = uni(8'd3);
    bias        = 8'd7;
    #2;
    checks++;
    if (output_pixel !== 10'd0) begin
      errors++;
      $display("FAIL reset_no_edge got %0d expected 0", output_pixel);
    end
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd0) begin
      errors++;
      $display("FAIL reset_held got %0d expected 0", output_pixel);
    end
    // first edge after release loads 9*99*3+7 = 2680 -> saturated
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd1023) begin
      errors++;
      $display("FAIL reset_release got %0d expected 1023", output_pixel);
    end
  endtask

  task automatic test_dot_product;
    apply(mk(10, 15, 20, 25, 30, 35, 40, 45, 50), uni(8'd2), 8'd1);
    #1;
    checks++;
    if (output_pixel !== 10'd1023) begin
      errors++;
      $display("FAIL latency_hold got %0d expected 1023", output_pixel);
    end
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd541) begin
      errors++;
      $display("FAIL dot_product got %0d expected 541", output_pixel);
    end
  endtask

  task automatic test_bias_only;
    apply(uni(8'd0), uni(8'd255), 8'd200);
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd200) begin
      errors++;
      $display("FAIL bias_only got %0d expected 200", output_pixel);
    end
  endtask

  task automatic test_saturation;
    apply(uni(8'd255), uni(8'd255), 8'd255);
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd1023) begin
      errors++;
      $display("FAIL saturate_max got %0d expected 1023", output_pixel);
    end
    // 4*255 = 1020 plus bias straddles the 1023 limit
    apply(mk(0, 0, 0, 0, 4, 0, 0, 0, 0), mk(0, 0, 0, 0, 255, 0, 0, 0, 0), 8'd2);
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd1022) begin
      errors++;
      $display("FAIL below_limit got %0d expected 1022", output_pixel);
    end
    bias = 8'd3;
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd1023) begin
      errors++;
      $display("FAIL at_limit got %0d expected 1023", output_pixel);
    end
    bias = 8'd4;
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd1023) begin
      errors++;
      $display("FAIL above_limit got %0d expected 1023", output_pixel);
    end
  endtask

  task automatic test_center_tap;
    apply(mk(255, 255, 255, 255, 77, 255, 255, 255, 255),
          mk(0, 0, 0, 0, 1, 0, 0, 0, 0), 8'd0);
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd77) begin
      errors++;
      $display("FAIL center_tap got %0d expected 77", output_pixel);
    end
  endtask

  task automatic test_asymmetric;
    // 3*15 + 1*40 = 85; a row/col swap would give 3*25 + 1*20 = 95
    apply(mk(10, 15, 20, 25, 30, 35, 40, 45, 50), mk(0, 3, 0, 0, 0, 0, 1, 0, 0), 8'd0);
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd85) begin
      errors++;
      $display("FAIL asymmetric got %0d expected 85", output_pixel);
    end
    // corner taps: 10*1 + 20*2 + 40*3 + 50*4 + bias 9 = 379
    apply(mk(10, 15, 20, 25, 30, 35, 40, 45, 50), mk(1, 0, 2, 0, 0, 0, 3, 0, 4), 8'd9);
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd379) begin
      errors++;
      $display("FAIL corners got %0d expected 379", output_pixel);
    end
  endtask

  task automatic test_back_to_back;
    apply(mk(10, 15, 20, 25, 30, 35, 40, 45, 50), uni(8'd2), 8'd1);
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd541) begin
      errors++;
      $display("FAIL b2b_first got %0d expected 541", output_pixel);
    end
    input_patch = mk(255, 255, 255, 255, 77, 255, 255, 255, 255);
    kernel      = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
    bias        = 8'd0;
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd77) begin
      errors++;
      $display("FAIL b2b_second got %0d expected 77", output_pixel);
    end
  endtask

  task automatic test_reset_mid_operation;
    apply(mk(10, 15, 20, 25, 30, 35, 40, 45, 50), uni(8'd2), 8'd1);
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd541) begin
      errors++;
      $display("FAIL mid_preload got %0d expected 541", output_pixel);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (output_pixel !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset_immediate got %0d expected 0", output_pixel);
    end
    input_patch = mk(255, 255, 255, 255, 77, 255, 255, 255, 255);
    kernel      = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
    bias        = 8'd0;
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset_held got %0d expected 0", output_pixel);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (output_pixel !== 10'd77) begin
      errors++;
      $display("FAIL mid_resume got %0d expected 77", output_pixel);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_dot_product();
    test_bias_only();
    test_saturation();
    test_center_tap();
    test_asymmetric();
    test_back_to_back();
    test_reset_mid_operation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
